run_ctrl: RTL
=============

Name: run_ctrl

Overview:
Run-mode controller for the 8-bit lossless JPEG-LS encoder, directly upstream of the run-interruption coding pipeline.
- Consumes the raster pixel stream with its causal neighbours Ra and Rb.
- Tracks run state, RUNindex and the run residual count.
- Emits run-segment bits to the bitstream merger.
- Hands interruption samples, already converted to x/px/sign/RItype/J form, to the interruption coder.
- Flags pixels that belong to the regular coding path.

Parameters:
BW, 8, pixel bit width; only 8 is supported.
IDX_MAX, 31, saturation value of RUNindex.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_vl  in  1  input pixel valid; one pixel per cycle, no backpressure
i_sof  in  1  first pixel of frame; qualified by i_vl
i_eol  in  1  last pixel of line; qualified by i_vl
i_rm  in  1  context gradients all zero, so run mode may start at this pixel
i_x  in  8  current pixel
i_a  in  8  Ra (left neighbour)
i_b  in  8  Rb (upper neighbour)
o_bvl  out  1  run bits valid
o_bv  out  16  run bits, right-aligned, MSB sent first
o_bc  out  5  number of valid bits in o_bv (0..16)
o_ri_vl  out  1  interruption sample valid
o_ri_x  out  8  interruption pixel
o_ri_px  out  8  interruption prediction
o_ri_s  out  1  sign-invert flag
o_ri_q  out  1  RItype
o_ri_cn  out  4  J[RUNindex] in force at the interruption
o_rg_vl  out  1  pixel goes to the regular coding path

Behaviour:
- J table, indexed by RUNindex 0..31: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15. Segment size rg = 1<<J.
- Latency: all outputs for a pixel appear exactly 2 cycles after its i_vl, aligned. At most one of o_bvl/o_rg_vl per pixel, except that o_bvl and o_ri_vl coincide on an interruption.
- Reset:
  - All o_*vl go to 0; data outputs go to 0.
  - RUNindex=0, residual=0, state=IDLE.
  - Reset mid-run discards the residual and emits no bits.
- i_sof with i_vl: RUNindex:=0, residual:=0, state:=IDLE before the pixel is processed.
- State IDLE:
  - i_rm=0: pixel is regular; o_rg_vl=1.
  - i_rm=1 and x==a: treated as a run pixel (see RUN).
  - i_rm=1 and x!=a: interruption with residual 0.
- State RUN: every pixel is a run pixel regardless of i_rm.
- Run pixel (x==a):
  - residual+1 == rg: emit a single '1' (bv=1, bc=1); residual:=0; RUNindex:=min(RUNindex+1, IDX_MAX).
  - Otherwise residual++.
  - If i_eol: after the update above, emit a single '1' if residual>0; residual:=0; state:=IDLE. A segment '1' and an EOL '1' never coincide.
  - Otherwise state:=RUN.
- Interruption (x!=a while in RUN, or the IDLE entry case above):
  - Run bits: '0' followed by J bits of residual. bv={0,residual[J-1:0]}, bc=J+1.
  - Interruption sample:
    - q = (a==b).
    - px = q ? a : b.
    - s = (~q) & (a>b).
    - cn = J at the current RUNindex.
    - x passed through as o_ri_x.
  - Then RUNindex:=RUNindex-1 if >0; residual:=0; state:=IDLE.
  - i_eol on the interruption pixel changes nothing extra.
- Widths:
  - residual is 15 bits and is always < rg (max 32767).
  - RUNindex is 5 bits and saturates at 31 (J=15).
  - o_bc max 16.
- i_vl=0 cycles hold all state; outputs show valid=0 two cycles later.

Test Plan:
- Reset/regular path: rst, then i_sof; pixel i_rm=0, x=5 -> 2 cycles later o_rg_vl=1, o_bvl=0, o_ri_vl=0.
- Run then interrupt, a==b: i_sof; 5 pixels x=a=b=7 (i_rm=1 on the first); then x=10, a=b=7 -> four bv=1/bc=1 outputs, fifth pixel emits nothing; sixth gives bv=0b01, bc=2, ri x=10, px=7, q=1, s=0, cn=1; RUNindex ends at 3.
- Immediate interrupt, a!=b: RUNindex=0, IDLE, i_rm=1, x=30, a=20, b=15 -> bv=0, bc=1; ri px=15, q=0, s=1, cn=0; RUNindex stays 0.
- EOL partial vs. full segment:
  - At RUNindex=4, one run pixel with i_eol -> bv=1/bc=1 (EOL bit); RUNindex stays 4; next i_rm=0 pixel is regular.
  - At RUNindex=4, two run pixels, second with i_eol -> a single '1' on the second pixel; RUNindex=5.
- Saturation: 33052 matching pixels from RUNindex=0 -> RUNindex=31; next 32768 pixels -> exactly one '1', RUNindex stays 31; interruption then gives bc=16, cn=15.
- sof/reset mid-run: at RUNindex=6 with residual=1, a pixel with i_sof and x!=a, i_rm=0 -> regular, no bits, RUNindex=0. rst asserted mid-run -> no output valids, RUNindex=0 afterwards.

Source files
------------

// File: rtl/run_ctrl.sv
// JPEG-LS run-mode controller: classifies each pixel as regular, run or
// run interruption and emits run bits / interruption samples two cycles later.
module run_ctrl #(
  parameter int BW      = 8,
  parameter int IDX_MAX = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vl,
  input  logic          i_sof,
  input  logic          i_eol,
  input  logic          i_rm,
  input  logic [BW-1:0] i_x,
  input  logic [BW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  output logic          o_bvl,
  output logic [15:0]   o_bv,
  output logic [4:0]    o_bc,
  output logic          o_ri_vl,
  output logic [BW-1:0] o_ri_x,
  output logic [BW-1:0] o_ri_px,
  output logic          o_ri_s,
  output logic          o_ri_q,
  output logic [3:0]    o_ri_cn,
  output logic          o_rg_vl
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic          bvl;
    logic [15:0]   bv;
    logic [4:0]    bc;
    logic          rivl;
    logic [BW-1:0] rix;
    logic [BW-1:0] ripx;
    logic          ris;
    logic          riq;
    logic [3:0]    ricn;
    logic          rgvl;
  } out_t;

  state_t      st_q, st_d, st_c;
  logic [4:0]  idx_q, idx_d, idx_c;
  logic [14:0] res_q, res_d, res_c;
  logic [3:0]  j;
  logic [15:0] rg, res_inc;
  out_t        s1_q, s1_d, s2_q;

  function automatic logic [3:0] j_of(input logic [4:0] idx);
    logic [3:0] r;
    case (idx)
      5'd0, 5'd1, 5'd2, 5'd3:     r = 4'd0;
      5'd4, 5'd5, 5'd6, 5'd7:     r = 4'd1;
      5'd8, 5'd9, 5'd10, 5'd11:   r = 4'd2;
      5'd12, 5'd13, 5'd14, 5'd15: r = 4'd3;
      5'd16, 5'd17:               r = 4'd4;
      5'd18, 5'd19:               r = 4'd5;
      5'd20, 5'd21:               r = 4'd6;
      5'd22, 5'd23:               r = 4'd7;
      default:                    r = 4'(idx - 5'd16);
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      idx_q <= '0;
      res_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      res_q <= res_d;
      s1_q  <= s1_d;
      s2_q  <= s1_q;
    end
  end

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    res_d = res_q;
    s1_d  = '0;
    // Start of frame clears run context before this pixel is classified.
    st_c    = (i_vl && i_sof) ? IDLE : st_q;
    idx_c   = (i_vl && i_sof) ? '0 : idx_q;
    res_c   = (i_vl && i_sof) ? '0 : res_q;
    j       = j_of(idx_c);
    rg      = 16'd1 << j;
    res_inc = {1'b0, res_c} + 16'd1;
    if (i_vl) begin
      st_d  = st_c;
      idx_d = idx_c;
      res_d = res_c;
      if (st_c == IDLE && !i_rm) begin
        s1_d.rgvl = 1'b1;
      end else if (i_x == i_a) begin
        res_d = res_inc[14:0];
        st_d  = RUN;
        if (res_inc == rg) begin
          s1_d.bvl = 1'b1;
          s1_d.bv  = 16'd1;
          s1_d.bc  = 5'd1;
          res_d    = '0;
          if (idx_c < 5'(IDX_MAX)) idx_d = idx_c + 5'd1;
        end
        // A completed segment already zeroed res_d, so the EOL bit cannot double up.
        if (i_eol) begin
          if (res_d != '0) begin
            s1_d.bvl = 1'b1;
            s1_d.bv  = 16'd1;
            s1_d.bc  = 5'd1;
          end
          res_d = '0;
          st_d  = IDLE;
        end
      end else begin
        s1_d.bvl  = 1'b1;
        s1_d.bv   = {1'b0, res_c} & (rg - 16'd1);
        s1_d.bc   = {1'b0, j} + 5'd1;
        s1_d.rivl = 1'b1;
        s1_d.rix  = i_x;
        s1_d.riq  = (i_a == i_b);
        s1_d.ripx = (i_a == i_b) ? i_a : i_b;
        s1_d.ris  = (i_a != i_b) && (i_a > i_b);
        s1_d.ricn = j;
        idx_d     = (idx_c != '0) ? idx_c - 5'd1 : '0;
        res_d     = '0;
        st_d      = IDLE;
      end
    end
  end

  assign o_bvl   = s2_q.bvl;
  assign o_bv    = s2_q.bv;
  assign o_bc    = s2_q.bc;
  assign o_ri_vl = s2_q.rivl;
  assign o_ri_x  = s2_q.rix;
  assign o_ri_px = s2_q.ripx;
  assign o_ri_s  = s2_q.ris;
  assign o_ri_q  = s2_q.riq;
  assign o_ri_cn = s2_q.ricn;
  assign o_rg_vl = s2_q.rgvl;

endmodule
